// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single word-addressed data-memory port between two requesters.
//   P0 (pipeline M-stage) has priority. P1 (aux/debug loader) is forced through
//   after STARVE_LIMIT consecutive cycles of losing to P0. An accepted access is
//   latched into a one-deep stage and drives the DM in the following cycle. Its
//   completion pulse (rvalid/err/rdata) follows one cycle after that. Accesses
//   that are misaligned or out of range are suppressed: they never reach the DM
//   and they complete with err=1.
// Ports
//   Clk, Reset             clock, async active-low reset
//   pN_req/we/addr/wdata   requester N access; hold stable until pN_gnt
//   pN_gnt                 combinational accept
//   pN_rvalid/err/rdata    one-cycle completion pulse for requester N
//   mem_addr/we/wdata      DM word index, write enable, write data
//   mem_rdata              DM combinational read data for mem_addr
//   busy                   access stage occupied
module dm_port_arbiter #(
   parameter int DEPTH        = 3072,
   parameter int ADDR_W       = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic              p0_err,
   output logic [31:0]       p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic              p1_err,
   output logic [31:0]       p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      LIMIT_L = 4'(STARVE_LIMIT);

   logic              s_valid;
   logic              s_id;      // 0 = P0, 1 = P1
   logic              s_we;
   logic [31:0]       s_addr;
   logic [31:0]       s_wdata;
   logic [3:0]        starve_cnt;

   logic              both;
   logic              p1_force;
   logic              legal;
   logic [ADDR_W-1:0] s_word;
   logic [31:0]       resp_data;

   // Arbitration. The stage reloads every cycle, so a grant never waits on
   // downstream space.
   always_comb begin
      both     = p0_req & p1_req;
      p1_force = both & (starve_cnt == LIMIT_L);
      p0_gnt   = p0_req & ~p1_force;
      p1_gnt   = p1_req & (~p0_req | p1_force);
   end

   assign s_word = s_addr[ADDR_W+1:2];
   assign legal  = (s_addr[1:0] == 2'b00) &&
                   (s_addr[31:ADDR_W+2] == '0) &&
                   ({1'b0, s_word} < DEPTH_L);

   // The DM only ever sees legal accesses. It is parked at zero otherwise.
   assign mem_we    = s_valid & legal & s_we;
   assign mem_addr  = (s_valid & legal) ? s_word  : '0;
   assign mem_wdata = (s_valid & legal) ? s_wdata : '0;
   assign busy      = s_valid;

   assign resp_data = (legal & ~s_we) ? mem_rdata : 32'h0;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s_valid    <= 1'b0;
         s_id       <= 1'b0;
         s_we       <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         starve_cnt <= '0;
         p0_rvalid  <= 1'b0;
         p0_err     <= 1'b0;
         p0_rdata   <= '0;
         p1_rvalid  <= 1'b0;
         p1_err     <= 1'b0;
         p1_rdata   <= '0;
      end else begin
         s_valid <= p0_gnt | p1_gnt;
         s_id    <= p1_gnt;
         if (p1_gnt) begin
            s_we    <= p1_we;
            s_addr  <= p1_addr;
            s_wdata <= p1_wdata;
         end else if (p0_gnt) begin
            s_we    <= p0_we;
            s_addr  <= p0_addr;
            s_wdata <= p0_wdata;
         end

         // Counts consecutive cycles in which P1 lost to P0. The forced win
         // at the limit keeps it from exceeding STARVE_LIMIT.
         if (p1_gnt || !p1_req)
            starve_cnt <= '0;
         else if (both)
            starve_cnt <= starve_cnt + 4'd1;

         // Completion. err and rvalid pulse together. rdata holds until the
         // next completion for that requester.
         p0_rvalid <= s_valid & ~s_id;
         p0_err    <= s_valid & ~s_id & ~legal;
         p1_rvalid <= s_valid & s_id;
         p1_err    <= s_valid & s_id & ~legal;
         if (s_valid & ~s_id) p0_rdata <= resp_data;
         if (s_valid &  s_id) p1_rdata <= resp_data;
      end
   end

endmodule
